// File: rtl/mfp_ahb_loader_arbiter.sv
// mfp_ahb_loader_arbiter: AHB-Lite arbiter between the CPU and the SREC loader, handing over only at transfer boundaries
module mfp_ahb_loader_arbiter #(
    parameter int          FIFO_DEPTH = 16,
    parameter int          MERGE_EN   = 1,
    parameter logic [31:0] WIN_BASE   = 32'h0000_0000,
    parameter logic [31:0] WIN_MASK   = 32'h0000_0000,
    parameter int          CNT_W      = 16
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             big_endian,
    input  logic             ld_active,
    input  logic [31:0]      ld_address,
    input  logic [7:0]       ld_byte,
    input  logic             ld_we,
    output logic             ld_full,
    input  logic [31:0]      m_HADDR,
    input  logic [2:0]       m_HBURST,
    input  logic             m_HMASTLOCK,
    input  logic [3:0]       m_HPROT,
    input  logic [2:0]       m_HSIZE,
    input  logic [1:0]       m_HTRANS,
    input  logic [31:0]      m_HWDATA,
    input  logic             m_HWRITE,
    output logic [31:0]      m_HRDATA,
    output logic             m_HREADY,
    output logic             m_HRESP,
    output logic [31:0]      s_HADDR,
    output logic [2:0]       s_HBURST,
    output logic             s_HMASTLOCK,
    output logic [3:0]       s_HPROT,
    output logic [2:0]       s_HSIZE,
    output logic [1:0]       s_HTRANS,
    output logic [31:0]      s_HWDATA,
    output logic             s_HWRITE,
    input  logic [31:0]      s_HRDATA,
    input  logic             s_HREADY,
    input  logic             s_HRESP,
    output logic             loader_owner,
    output logic [CNT_W-1:0] wr_count,
    output logic [CNT_W-1:0] drop_count,
    output logic [CNT_W-1:0] err_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {CPU, LOAD, REPLAY} state_t;
    state_t        state, nxt;
    logic [31:0]   f_addr [FIFO_DEPTH];
    logic [7:0]    f_data [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, pop_n;
    logic [31:0]   cap_haddr, wdata_q, wdata_n, a0, a1, a2, a3;
    logic [7:0]    d0, d1, d2, d3;
    logic [2:0]    cap_hburst, cap_hsize;
    logic [3:0]    cap_hprot;
    logic [1:0]    cap_htrans;
    logic          cap_hmastlock, cap_hwrite, pend, push, go, merge, empty, grab;

    assign empty        = count == '0;
    assign ld_full      = count == (AW+1)'(FIFO_DEPTH);
    assign push         = ld_we && ((ld_address & WIN_MASK) == (WIN_BASE & WIN_MASK)) && !ld_full;
    assign a0           = f_addr[rd_ptr];
    assign a1           = f_addr[rd_ptr + AW'(1)];
    assign a2           = f_addr[rd_ptr + AW'(2)];
    assign a3           = f_addr[rd_ptr + AW'(3)];
    assign d0           = f_data[rd_ptr];
    assign d1           = f_data[rd_ptr + AW'(1)];
    assign d2           = f_data[rd_ptr + AW'(2)];
    assign d3           = f_data[rd_ptr + AW'(3)];
    assign merge        = (MERGE_EN != 0) && count >= (AW+1)'(4) && a0[1:0] == 2'b00 &&
                          a1 == a0 + 32'd1 && a2 == a0 + 32'd2 && a3 == a0 + 32'd3;
    assign wdata_n      = merge ? (big_endian ? {d0, d1, d2, d3} : {d3, d2, d1, d0}) : {4{d0}};
    assign go           = state == LOAD && !pend && !empty && s_HREADY;
    assign pop_n        = go ? (merge ? (AW+1)'(4) : (AW+1)'(1)) : '0;
    assign grab         = state == CPU && ld_active && s_HREADY;
    assign loader_owner = state == LOAD;

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge HCLK)
        if (push) begin
            f_addr[wr_ptr] <= ld_address;
            f_data[wr_ptr] <= ld_byte;
        end

    // ownership state and the CPU address phase caught at handover
    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) begin
            state         <= CPU;
            cap_haddr     <= '0;
            cap_hburst    <= '0;
            cap_hmastlock <= 1'b0;
            cap_hprot     <= '0;
            cap_hsize     <= '0;
            cap_htrans    <= '0;
            cap_hwrite    <= 1'b0;
        end else begin
            state <= nxt;
            if (grab) begin
                cap_haddr     <= m_HADDR;
                cap_hburst    <= m_HBURST;
                cap_hmastlock <= m_HMASTLOCK;
                cap_hprot     <= m_HPROT;
                cap_hsize     <= m_HSIZE;
                cap_htrans    <= m_HTRANS;
                cap_hwrite    <= m_HWRITE;
            end
        end

    // FIFO pointers; a full FIFO rejects the push even when a pop happens the same cycle
    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_ptr + pop_n[AW-1:0];
            count  <= count + (AW+1)'(push) - pop_n;
        end

    // loader data phase tracking and saturating status counters
    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) begin
            pend       <= 1'b0;
            wdata_q    <= '0;
            wr_count   <= '0;
            drop_count <= '0;
            err_count  <= '0;
        end else begin
            if (go) begin
                pend    <= 1'b1;
                wdata_q <= wdata_n;
            end else if (pend && s_HREADY) pend <= 1'b0;
            if (pend && s_HREADY && ~&wr_count) wr_count <= wr_count + CNT_W'(1);
            if (pend && s_HREADY && s_HRESP && ~&err_count) err_count <= err_count + CNT_W'(1);
            if (ld_we && !push && ~&drop_count) drop_count <= drop_count + CNT_W'(1);
        end

    // bus steering and next ownership state
    always_comb begin
        nxt         = state;
        s_HADDR     = m_HADDR;
        s_HBURST    = m_HBURST;
        s_HMASTLOCK = m_HMASTLOCK;
        s_HPROT     = m_HPROT;
        s_HSIZE     = m_HSIZE;
        s_HTRANS    = m_HTRANS;
        s_HWDATA    = m_HWDATA;
        s_HWRITE    = m_HWRITE;
        m_HRDATA    = s_HRDATA;
        m_HREADY    = s_HREADY;
        m_HRESP     = s_HRESP;
        case (state)
            CPU: if (grab) begin
                s_HTRANS = 2'b00;
                nxt      = LOAD;
            end
            LOAD: begin
                m_HREADY    = 1'b0;
                m_HRESP     = 1'b0;
                s_HADDR     = a0;
                s_HBURST    = 3'b000;
                s_HMASTLOCK = 1'b0;
                s_HPROT     = 4'b0011;
                s_HSIZE     = merge ? 3'd2 : 3'd0;
                s_HTRANS    = (!pend && !empty) ? 2'b10 : 2'b00;
                s_HWDATA    = wdata_q;
                s_HWRITE    = 1'b1;
                if (!ld_active && empty && !pend) nxt = cap_htrans[1] ? REPLAY : CPU;
            end
            REPLAY: begin
                m_HREADY    = 1'b0;
                m_HRESP     = 1'b0;
                s_HADDR     = cap_haddr;
                s_HBURST    = cap_hburst;
                s_HMASTLOCK = cap_hmastlock;
                s_HPROT     = cap_hprot;
                s_HSIZE     = cap_hsize;
                s_HTRANS    = cap_htrans;
                s_HWRITE    = cap_hwrite;
                if (s_HREADY) nxt = CPU;
            end
            default: nxt = CPU;
        endcase
    end
endmodule

// File: tb/tb_mfp_ahb_loader_arbiter.sv
// tb_mfp_ahb_loader_arbiter: scoreboard bench for the CPU/loader AHB arbiter
module tb_mfp_ahb_loader_arbiter;
    logic        HCLK = 1'b0, HRESETn = 1'b0, big_endian = 1'b0, ld_active = 1'b0, ld_we = 1'b0;
    logic [31:0] ld_address = '0;
    logic [7:0]  ld_byte = '0;
    logic        ld_full, loader_owner;
    logic [31:0] m_HADDR = '0, m_HWDATA = '0, m_HRDATA;
    logic [2:0]  m_HBURST = '0, m_HSIZE = '0;
    logic        m_HMASTLOCK = 1'b0, m_HWRITE = 1'b0, m_HREADY, m_HRESP;
    logic [3:0]  m_HPROT = '0;
    logic [1:0]  m_HTRANS = '0;
    logic [31:0] s_HADDR, s_HWDATA, s_HRDATA = '0;
    logic [2:0]  s_HBURST, s_HSIZE;
    logic        s_HMASTLOCK, s_HWRITE, s_HREADY = 1'b1, s_HRESP = 1'b0;
    logic [3:0]  s_HPROT;
    logic [1:0]  s_HTRANS;
    logic [15:0] wr_count, drop_count, err_count;

    typedef struct {
        logic [31:0] a;
        logic [2:0]  s;
        logic [31:0] d;
    } wr_t;
    wr_t  exp_q[$];
    wr_t  cur;
    logic dphase = 1'b0;
    int   n_chk = 0, n_fail = 0, exp_wr = 0, exp_drop = 0, exp_err = 0;

    always #5 HCLK = ~HCLK;

    mfp_ahb_loader_arbiter #(.WIN_BASE(32'h0000_0000), .WIN_MASK(32'hFFF0_0000)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .big_endian(big_endian), .ld_active(ld_active),
        .ld_address(ld_address), .ld_byte(ld_byte), .ld_we(ld_we), .ld_full(ld_full),
        .m_HADDR(m_HADDR), .m_HBURST(m_HBURST), .m_HMASTLOCK(m_HMASTLOCK), .m_HPROT(m_HPROT),
        .m_HSIZE(m_HSIZE), .m_HTRANS(m_HTRANS), .m_HWDATA(m_HWDATA), .m_HWRITE(m_HWRITE),
        .m_HRDATA(m_HRDATA), .m_HREADY(m_HREADY), .m_HRESP(m_HRESP),
        .s_HADDR(s_HADDR), .s_HBURST(s_HBURST), .s_HMASTLOCK(s_HMASTLOCK), .s_HPROT(s_HPROT),
        .s_HSIZE(s_HSIZE), .s_HTRANS(s_HTRANS), .s_HWDATA(s_HWDATA), .s_HWRITE(s_HWRITE),
        .s_HRDATA(s_HRDATA), .s_HREADY(s_HREADY), .s_HRESP(s_HRESP),
        .loader_owner(loader_owner), .wr_count(wr_count), .drop_count(drop_count), .err_count(err_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic put(input logic [31:0] a, input logic [7:0] d);
        ld_we      = 1'b1;
        ld_address = a;
        ld_byte    = d;
        cyc();
        ld_we      = 1'b0;
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        wr_t w;
        w.a = a;
        w.s = s;
        w.d = d;
        exp_q.push_back(w);
    endtask

    task automatic check_counts();
        check("wr_count", 32'(wr_count), 32'(exp_wr));
        check("drop_count", 32'(drop_count), 32'(exp_drop));
        check("err_count", 32'(err_count), 32'(exp_err));
    endtask

    task automatic wait_owner_low();
        int n = 0;
        @(negedge HCLK);
        while (loader_owner && n < 100) begin
            @(negedge HCLK);
            n++;
        end
        check("load_done", 32'(loader_owner), 32'd0);
    endtask

    task automatic run_load();
        ld_active = 1'b1;
        cyc();
        ld_active = 1'b0;
        wait_owner_low();
        check_counts();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        cyc();
    endtask

    // observe loader transfers on the slave bus and compare them with the scoreboard
    always @(negedge HCLK) begin
        if (!HRESETn) dphase = 1'b0;
        else begin
            if (dphase && s_HREADY) begin
                check("ld_hwdata", s_HWDATA, cur.d);
                dphase = 1'b0;
            end
            if (loader_owner && s_HTRANS == 2'b10 && s_HREADY) begin
                check("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    check("ld_haddr", s_HADDR, cur.a);
                    check("ld_hsize", 32'(s_HSIZE), 32'(cur.s));
                    check("ld_ctrl", 32'({s_HWRITE, s_HBURST, s_HPROT, s_HMASTLOCK}), 32'({1'b1, 3'b000, 4'b0011, 1'b0}));
                    dphase = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check("rst_owner", 32'(loader_owner), 32'd0);
        check("rst_full", 32'(ld_full), 32'd0);
        check_counts();
        cyc();
        cyc();
        HRESETn = 1'b1;
        cyc();
        for (int i = 0; i < 30; i++) begin
            m_HADDR     = $urandom;
            m_HBURST    = 3'($urandom);
            m_HMASTLOCK = 1'($urandom);
            m_HPROT     = 4'($urandom);
            m_HSIZE     = 3'($urandom);
            m_HTRANS    = 2'($urandom);
            m_HWDATA    = $urandom;
            m_HWRITE    = 1'($urandom);
            s_HRDATA    = $urandom;
            s_HREADY    = 1'($urandom);
            s_HRESP     = 1'($urandom);
            @(negedge HCLK);
            check("pt_haddr", s_HADDR, m_HADDR);
            check("pt_ctrl", 32'({s_HBURST, s_HMASTLOCK, s_HPROT, s_HSIZE, s_HTRANS, s_HWRITE}),
                  32'({m_HBURST, m_HMASTLOCK, m_HPROT, m_HSIZE, m_HTRANS, m_HWRITE}));
            check("pt_hwdata", s_HWDATA, m_HWDATA);
            check("pt_hrdata", m_HRDATA, s_HRDATA);
            check("pt_ready_resp", 32'({m_HREADY, m_HRESP, loader_owner}), 32'({s_HREADY, s_HRESP, 1'b0}));
            cyc();
        end
        m_HBURST = '0; m_HMASTLOCK = 1'b0; m_HPROT = 4'b0011; s_HRESP = 1'b0; s_HREADY = 1'b1;
        m_HADDR = 32'h1F00_0000; m_HTRANS = 2'b10; m_HWRITE = 1'b1; m_HSIZE = 3'd2;
        cyc();
        m_HWDATA = 32'h1234_5678; m_HADDR = 32'h1F00_0004; m_HWRITE = 1'b0; s_HREADY = 1'b0; ld_active = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            check("ho_wait_ready", 32'({m_HREADY, loader_owner}), 32'd0);
            check("ho_sw_data", s_HWDATA, 32'h1234_5678);
            cyc();
        end
        s_HREADY = 1'b1;
        @(negedge HCLK);
        check("ho_idle_forced", 32'(s_HTRANS), 32'd0);
        check("ho_sw_done", 32'(m_HREADY), 32'd1);
        cyc();
        m_HTRANS = 2'b00; m_HADDR = '0;
        @(negedge HCLK);
        check("ho_load", 32'({loader_owner, m_HREADY}), 32'({1'b1, 1'b0}));
        expect_wr(32'h30, 3'd0, 32'h5A5A_5A5A);
        put(32'h30, 8'h5A);
        ld_active = 1'b0;
        exp_wr = 1;
        wait_owner_low();
        check("rp_haddr", s_HADDR, 32'h1F00_0004);
        check("rp_ctrl", 32'({s_HTRANS, s_HWRITE, s_HSIZE, m_HREADY}), 32'({2'b10, 1'b0, 3'd2, 1'b0}));
        cyc();
        s_HRDATA = 32'hCAFE_F00D;
        @(negedge HCLK);
        check("rp_lw_data", m_HRDATA, 32'hCAFE_F00D);
        check("rp_lw_ready", 32'({m_HREADY, loader_owner}), 32'({1'b1, 1'b0}));
        check_counts();
        cyc();
        put(32'h10, 8'h11); put(32'h11, 8'h22); put(32'h12, 8'h33); put(32'h13, 8'h44);
        expect_wr(32'h10, 3'd2, 32'h4433_2211);
        exp_wr++;
        run_load();
        big_endian = 1'b1;
        put(32'h10, 8'h11); put(32'h11, 8'h22); put(32'h12, 8'h33); put(32'h13, 8'h44);
        expect_wr(32'h10, 3'd2, 32'h1122_3344);
        exp_wr++;
        run_load();
        big_endian = 1'b0;
        put(32'h21, 8'hBB); put(32'h22, 8'hCC); put(32'h23, 8'hDD);
        expect_wr(32'h21, 3'd0, 32'hBBBB_BBBB);
        expect_wr(32'h22, 3'd0, 32'hCCCC_CCCC);
        expect_wr(32'h23, 3'd0, 32'hDDDD_DDDD);
        exp_wr += 3;
        run_load();
        s_HRESP = 1'b1;
        put(32'h40, 8'h77);
        expect_wr(32'h40, 3'd0, 32'h7777_7777);
        exp_wr++;
        exp_err++;
        run_load();
        s_HRESP = 1'b0;
        put(32'h1FC0_0000, 8'h99);
        exp_drop++;
        @(negedge HCLK);
        check_counts();
        cyc();
        ld_active = 1'b1;
        cyc();
        s_HREADY = 1'b0;
        for (int j = 0; j < 4; j++)
            expect_wr(32'h100 + 32'(4 * j), 3'd2, {8'(4 * j + 3), 8'(4 * j + 2), 8'(4 * j + 1), 8'(4 * j)});
        for (int i = 0; i < 20; i++) put(32'h100 + 32'(i), 8'(i));
        exp_drop += 4;
        @(negedge HCLK);
        check("burst_full", 32'(ld_full), 32'd1);
        check("burst_owner", 32'(loader_owner), 32'd1);
        check_counts();
        cyc();
        s_HREADY = 1'b1;
        m_HADDR = 32'hA5A5_0000; m_HTRANS = 2'b10;
        cyc();
        s_HREADY = 1'b0;
        #2 HRESETn = 1'b0;
        #1;
        check("arst_owner", 32'(loader_owner), 32'd0);
        check("arst_full", 32'(ld_full), 32'd0);
        check("arst_passthru", s_HADDR, 32'hA5A5_0000);
        check("arst_htrans", 32'(s_HTRANS), 32'd2);
        exp_q.delete();
        exp_wr = 0; exp_drop = 0; exp_err = 0;
        check_counts();
        ld_active = 1'b0;
        cyc();
        cyc();
        HRESETn = 1'b1;
        s_HREADY = 1'b1;
        cyc();
        @(negedge HCLK);
        check("post_rst", 32'({loader_owner, ld_full}), 32'd0);
        check_counts();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
